mem_stage: RTL and testbench

Parametrised memory-access (MEM) pipeline stage for the five-stage in-order core. It sits between EXE and WB and owns the data-memory port. The data-memory port uses a request/response handshake (`req`/`addr_ok`/`data_ok`) with variable latency. The stage supports byte, halfword, word and (when `DATA_W=64`) doubleword loads and stores, with sign/zero extension and misalignment detection.

---
 rtl/mem_bus_if.sv | 28 ++
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// Variable latency: addr_ok accepts a request, data_ok returns its response.
interface mem_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output data_req, data_wr, data_size,
    output data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size,
    input  data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: owns the data-memory port, one outstanding request,
// byte/half/word/double loads and stores with misalignment detection.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [DATA_W-1:0] ex_rkd_value,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  mem_bus_if.master         bus,
  input  logic              wb_allowin,
  output logic              mem_to_wb_valid,
  output logic [ADDR_W-1:0] mem_pc,
  output logic              mem_rf_we,
  output logic [RF_AW-1:0]  mem_rf_waddr,
  output logic [DATA_W-1:0] mem_rf_wdata,
  output logic              mem_ale
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic              mem_valid;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] alu_q;
  logic              rd_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] rkd_q;
  logic              rfwe_q;
  logic [RF_AW-1:0]  waddr_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              ex_go;
  logic              mis_q;
  logic              ready_go;
  logic [DATA_W-1:0] load_data;

  // Size 3 has no legal alignment on a 32-bit bus.
  function automatic logic misal(
    input logic [2:0] a,
    input logic [1:0] sz,
    input logic       memop
  );
    logic m;
    case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      default: m = (DATA_W == 32) | (|a);
    endcase
    return memop & m;
  endfunction

  assign ex_go = (ex_mem_rd | ex_mem_wr) &
                 ~misal(ex_alu_result[2:0],
                        ex_mem_size,
                        ex_mem_rd | ex_mem_wr);
  assign mis_q = misal(alu_q[2:0], size_q, rd_q | wr_q);

  always_comb begin
    ready_go = 1'b0;
    unique case (1'b1)
      state == S_IDLE: ready_go = ~(rd_q | wr_q) | mis_q;
      state == S_DONE: ready_go = 1'b1;
      default:         ready_go = 1'b0;
    endcase
  end

  assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
  assign accept          = ex_to_mem_valid & mem_allowin;
  assign mem_to_wb_valid = mem_valid & ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rkd_q     <= '0;
      rfwe_q    <= 1'b0;
      waddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        mem_valid <= 1'b1;
        pc_q      <= ex_pc;
        alu_q     <= ex_alu_result;
        rd_q      <= ex_mem_rd;
        wr_q      <= ex_mem_wr;
        size_q    <= ex_mem_size;
        uns_q     <= ex_mem_unsigned;
        rkd_q     <= ex_rkd_value;
        rfwe_q    <= ex_rf_we;
        waddr_q   <= ex_rf_waddr;
      end else begin
        mem_valid <= mem_valid & ~(ready_go & wb_allowin);
      end
      if (state == S_WAIT && bus.data_data_ok)
        rdata_q <= bus.data_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept & ex_go) state_n = S_REQ;
      S_REQ:  if (bus.data_addr_ok) state_n = S_WAIT;
      S_WAIT: if (bus.data_data_ok) state_n = S_DONE;
      S_DONE: if (wb_allowin)
                state_n = (accept & ex_go) ? S_REQ : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Request fields come from latched state, so they hold while data_req is up.
  always_comb begin
    int off;
    int sz;
    off = int'(alu_q[OFF_W-1:0]);
    sz  = int'(size_q);
    bus.data_req   = (state == S_REQ);
    bus.data_wr    = wr_q;
    bus.data_size  = size_q;
    bus.data_addr  = ADDR_W'(alu_q);
    bus.data_wstrb = '0;
    bus.data_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      bus.data_wstrb[i] = wr_q & (i >= off) &
                          (i < off + (1 << sz));
      bus.data_wdata[8*i +: 8] =
        rkd_q[8*(i % (1 << sz)) +: 8];
    end
  end

  always_comb begin
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] m;
    logic              sb;
    int                nbits;
    sh    = rdata_q >> (8 * int'(alu_q[OFF_W-1:0]));
    nbits = 8 << int'(size_q);
    m     = '0;
    sb    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      m[i] = (i < nbits);
      if (i == nbits - 1) sb = sh[i];
    end
    load_data = (sh & m) |
                ({DATA_W{~uns_q & sb}} & ~m);
  end

  assign mem_pc       = pc_q;
  assign mem_rf_waddr = waddr_q;
  assign mem_rf_we    = mem_valid & rfwe_q & ~mis_q;
  assign mem_ale      = mem_valid & mis_q;
  assign mem_rf_wdata = rd_q ? load_data : alu_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (DATA_W=32): ALU pass-through, loads,
// stores, misalignment, back-pressure and reset mid-transaction.
module tb_mem_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ex_to_mem_valid = 1'b0;
  logic          mem_allowin;
  logic [AW-1:0] ex_pc = '0;
  logic [DW-1:0] ex_alu_result = '0;
  logic          ex_mem_rd = 1'b0;
  logic          ex_mem_wr = 1'b0;
  logic [1:0]    ex_mem_size = '0;
  logic          ex_mem_unsigned = 1'b0;
  logic [DW-1:0] ex_rkd_value = '0;
  logic          ex_rf_we = 1'b0;
  logic [RW-1:0] ex_rf_waddr = '0;
  logic          wb_allowin = 1'b1;
  logic          mem_to_wb_valid;
  logic [AW-1:0] mem_pc;
  logic          mem_rf_we;
  logic [RW-1:0] mem_rf_waddr;
  logic [DW-1:0] mem_rf_wdata;
  logic          mem_ale;

  int n_run  = 0;
  int n_fail = 0;

  mem_bus_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_stage #(.DATA_W(DW), .ADDR_W(AW), .RF_AW(RW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_to_mem_valid (ex_to_mem_valid),
    .mem_allowin     (mem_allowin),
    .ex_pc           (ex_pc),
    .ex_alu_result   (ex_alu_result),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_wr       (ex_mem_wr),
    .ex_mem_size     (ex_mem_size),
    .ex_mem_unsigned (ex_mem_unsigned),
    .ex_rkd_value    (ex_rkd_value),
    .ex_rf_we        (ex_rf_we),
    .ex_rf_waddr     (ex_rf_waddr),
    .bus             (bus),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_pc          (mem_pc),
    .mem_rf_we       (mem_rf_we),
    .mem_rf_waddr    (mem_rf_waddr),
    .mem_rf_wdata    (mem_rf_wdata),
    .mem_ale         (mem_ale)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [AW-1:0] pc,
    input logic [DW-1:0] alu,
    input logic          rd,
    input logic          wr,
    input logic [1:0]    sz,
    input logic          uns,
    input logic [DW-1:0] rkd,
    input logic          we,
    input logic [RW-1:0] wa
  );
    ex_to_mem_valid = 1'b1;
    ex_pc           = pc;
    ex_alu_result   = alu;
    ex_mem_rd       = rd;
    ex_mem_wr       = wr;
    ex_mem_size     = sz;
    ex_mem_unsigned = uns;
    ex_rkd_value    = rkd;
    ex_rf_we        = we;
    ex_rf_waddr     = wa;
  endtask

  initial begin
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    #12;
    check("rst_allowin", 64'(mem_allowin), 64'd1);
    check("rst_valid", 64'(mem_to_wb_valid), 64'd0);
    check("rst_req", 64'(bus.data_req), 64'd0);
    check("rst_we", 64'(mem_rf_we), 64'd0);
    check("rst_ale", 64'(mem_ale), 64'd0);
    check("rst_pc", 64'(mem_pc), 64'd0);
    check("rst_waddr", 64'(mem_rf_waddr), 64'd0);
    check("rst_wdata", 64'(mem_rf_wdata), 64'd0);
    tick;
    resetn = 1'b1;

    // ALU op passes through in one cycle
    send(32'h100, 32'h1234_5678, 0, 0, 2'd2, 0, 0, 1, 5'd5);
    #1 check("alu_allowin", 64'(mem_allowin), 64'd1);
    tick;
    ex_to_mem_valid = 1'b0;
    #1;
    check("alu_valid", 64'(mem_to_wb_valid), 64'd1);
    check("alu_wdata", 64'(mem_rf_wdata), 64'h1234_5678);
    check("alu_we", 64'(mem_rf_we), 64'd1);
    check("alu_waddr", 64'(mem_rf_waddr), 64'd5);
    check("alu_pc", 64'(mem_pc), 64'h100);
    check("alu_req", 64'(bus.data_req), 64'd0);
    tick;
    check("alu_drain", 64'(mem_to_wb_valid), 64'd0);

    // ld.b signed at 0x1003, addr_ok cycle 0, data_ok cycle 3
    send(32'h104, 32'h1003, 1, 0, 2'd0, 0, 0, 1, 5'd7);
    bus.data_addr_ok = 1'b1;
    tick;
    ex_to_mem_valid = 1'b0;
    #1;
    check("ldb_req0", 64'(bus.data_req), 64'd1);
    check("ldb_addr", 64'(bus.data_addr), 64'h1003);
    check("ldb_wr", 64'(bus.data_wr), 64'd0);
    check("ldb_size", 64'(bus.data_size), 64'd0);
    check("ldb_v0", 64'(mem_to_wb_valid), 64'd0);
    tick;
    bus.data_addr_ok = 1'b0;
    check("ldb_req1", 64'(bus.data_req), 64'd0);
    tick;
    check("ldb_req2", 64'(bus.data_req), 64'd0);
    check("ldb_v2", 64'(mem_to_wb_valid), 64'd0);
    tick;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h80FF_0000;
    #1 check("ldb_v3", 64'(mem_to_wb_valid), 64'd0);
    tick;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    #1;
    check("ldb_v4", 64'(mem_to_wb_valid), 64'd1);
    check("ldb_wdata", 64'(mem_rf_wdata), 64'hFFFF_FF80);
    check("ldb_we", 64'(mem_rf_we), 64'd1);
    check("ldb_waddr", 64'(mem_rf_waddr), 64'd7);
    tick;
    check("ldb_drain", 64'(mem_to_wb_valid), 64'd0);

    // st.h at 0x2002, addr_ok two cycles late
    send(32'h108, 32'h2002, 0, 1, 2'd1, 0, 32'h0000_ABCD, 0, 5'd0);
    tick;
    ex_to_mem_valid = 1'b0;
    #1;
    check("sth_req0", 64'(bus.data_req), 64'd1);
    check("sth_wstrb", 64'(bus.data_wstrb), 64'hC);
    check("sth_wdata", 64'(bus.data_wdata), 64'hABCD_ABCD);
    check("sth_wr", 64'(bus.data_wr), 64'd1);
    check("sth_addr", 64'(bus.data_addr), 64'h2002);
    tick;
    check("sth_req1", 64'(bus.data_req), 64'd1);
    check("sth_wstrb1", 64'(bus.data_wstrb), 64'hC);
    tick;
    bus.data_addr_ok = 1'b1;
    #1 check("sth_req2", 64'(bus.data_req), 64'd1);
    tick;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    check("sth_req3", 64'(bus.data_req), 64'd0);
    tick;
    bus.data_data_ok = 1'b0;
    #1;
    check("sth_valid", 64'(mem_to_wb_valid), 64'd1);
    check("sth_we", 64'(mem_rf_we), 64'd0);
    tick;

    // misaligned ld.w passes in one cycle without a request
    send(32'h10C, 32'h3001, 1, 0, 2'd2, 0, 0, 1, 5'd3);
    tick;
    ex_to_mem_valid = 1'b0;
    #1;
    check("ale_flag", 64'(mem_ale), 64'd1);
    check("ale_valid", 64'(mem_to_wb_valid), 64'd1);
    check("ale_req", 64'(bus.data_req), 64'd0);
    check("ale_we", 64'(mem_rf_we), 64'd0);
    tick;
    check("ale_drain", 64'(mem_to_wb_valid), 64'd0);
    check("ale_clr", 64'(mem_ale), 64'd0);

    // doubleword on a 32-bit bus is always misaligned
    send(32'h110, 32'h3000, 1, 0, 2'd3, 0, 0, 1, 5'd3);
    tick;
    ex_to_mem_valid = 1'b0;
    #1;
    check("ald_flag", 64'(mem_ale), 64'd1);
    check("ald_req", 64'(bus.data_req), 64'd0);
    tick;

    // back-pressure in DONE, then back-to-back load
    send(32'h114, 32'h4000, 1, 0, 2'd2, 1, 0, 1, 5'd9);
    bus.data_addr_ok = 1'b1;
    tick;
    ex_to_mem_valid = 1'b0;
    wb_allowin = 1'b0;
    tick;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEAD_BEEF;
    tick;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    send(32'h118, 32'h5006, 1, 0, 2'd1, 1, 0, 1, 5'd10);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_allowin", 64'(mem_allowin), 64'd0);
      check("bp_valid", 64'(mem_to_wb_valid), 64'd1);
      check("bp_wdata", 64'(mem_rf_wdata), 64'hDEAD_BEEF);
      check("bp_pc", 64'(mem_pc), 64'h114);
      tick;
    end
    wb_allowin = 1'b1;
    #1 check("bp_release", 64'(mem_allowin), 64'd1);
    tick;
    ex_to_mem_valid = 1'b0;
    #1;
    check("b2b_req", 64'(bus.data_req), 64'd1);
    check("b2b_addr", 64'(bus.data_addr), 64'h5006);
    check("b2b_pc", 64'(mem_pc), 64'h118);
    bus.data_addr_ok = 1'b1;
    tick;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h8765_ABCD;
    tick;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    #1;
    check("ldhu_valid", 64'(mem_to_wb_valid), 64'd1);
    check("ldhu_wdata", 64'(mem_rf_wdata), 64'h0000_8765);
    tick;

    // reset while waiting for data_ok
    send(32'h11C, 32'h6000, 1, 0, 2'd2, 0, 0, 1, 5'd11);
    bus.data_addr_ok = 1'b1;
    tick;
    ex_to_mem_valid = 1'b0;
    tick;
    bus.data_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rw_req", 64'(bus.data_req), 64'd0);
    check("rw_valid", 64'(mem_to_wb_valid), 64'd0);
    check("rw_allowin", 64'(mem_allowin), 64'd1);
    tick;
    resetn = 1'b1;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h5555_5555;
    tick;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    #1;
    check("late_valid", 64'(mem_to_wb_valid), 64'd0);
    check("late_req", 64'(bus.data_req), 64'd0);
    check("late_wdata", 64'(mem_rf_wdata), 64'd0);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
